// File: rtl/gf_2m_pow_seq.sv
// gf_2m_pow_seq
// Sequential GF(2^m) exponentiation / inversion unit. Computes y = a^e in
// the field GF(2)[x]/(x^m + p) by left-to-right square-and-multiply, one
// exponent bit per clock. In inverse mode the exponent is forced to 2^m - 2,
// giving y = a^(-1). A zero operand in inverse mode raises zero_div.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any operation)
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   a          base element (m bits)
//   e          exponent, unsigned (ignored when inv = 1)
//   p          low coefficients of the field polynomial; x^m is implicit
//   inv        1 = compute inverse, 0 = compute a^e
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   y          registered result
//   zero_div   registered flag: inverse of zero requested
module gf_2m_pow_seq #(
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [m-1:0] a,
    input  logic [m-1:0] e,
    input  logic [m-1:0] p,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [m-1:0] y,
    output logic         zero_div
);

    localparam int KW = $clog2(m);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [m-1:0]   r_y;
    logic           r_zero_div;
    logic [m-1:0]   r_a;
    logic [m-1:0]   r_e;
    logic [m-1:0]   r_p;
    logic [m-1:0]   r_acc;
    logic [KW-1:0]  r_k;
    logic           r_zd_next;

    logic [m-1:0]   w_sq;
    logic [m-1:0]   w_next;

    // Shift-and-add field multiply, MSB of the multiplier first. Each step
    // multiplies the partial result by x (reducing x^m back to p) and then
    // conditionally adds the multiplicand, so the result never exceeds m bits.
    function automatic logic [m-1:0] gfMul(
        input logic [m-1:0] x,
        input logic [m-1:0] z,
        input logic [m-1:0] poly
    );
        logic [m-1:0] acc;
        acc = '0;
        for (int i = m - 1; i >= 0; i--) begin
            acc = {acc[m-2:0], 1'b0} ^ (acc[m-1] ? poly : '0);
            if (z[i]) begin
                acc = acc ^ x;
            end
        end
        return acc;
    endfunction

    // One square-and-multiply step: square the accumulator, then multiply by
    // the base only when the current exponent bit is set.
    always_comb begin
        w_sq   = gfMul(r_acc, r_acc, r_p);
        w_next = r_e[r_k] ? gfMul(w_sq, r_a, r_p) : w_sq;
    end

    // Control FSM and datapath registers. Operands are captured on accept so
    // the input pins are free to change while the operation runs. y and
    // zero_div are only written on the final RUN edge, so they stay stable
    // through the whole DONE backpressure period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero_div  <= 1'b0;
            r_a         <= '0;
            r_e         <= '0;
            r_p         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_zd_next   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_p        <= p;
                        r_e        <= inv ? {{(m-1){1'b1}}, 1'b0} : e;
                        r_zd_next  <= inv && (a == '0);
                        r_acc      <= {{(m-1){1'b0}}, 1'b1};
                        r_k        <= KW'(m - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_next;
                    if (r_k == '0) begin
                        r_y         <= w_next;
                        r_zero_div  <= r_zd_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k - KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero_div  = r_zero_div;

endmodule

// File: tb/tb_gf_2m_pow_seq.sv
// tb_gf_2m_pow_seq
// Self-checking bench for gf_2m_pow_seq at m = 4, p = x^4 + x + 1.
// Requests push their expected {zero_div, y} into a queue; an independent
// monitor pops and compares every time a result is handed over.
module tb_gf_2m_pow_seq;

    localparam int         M    = 4;
    localparam logic [3:0] POLY = 4'h3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] e;
    logic [3:0] p;
    logic       inv;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       zero_div;

    int         checks    = 0;
    int         errors    = 0;
    int         readyMode = 1;
    int         popCount  = 0;
    logic [4:0] expQ[$];
    logic [4:0] expItem;

    gf_2m_pow_seq #(.m(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .e         (e),
        .p         (p),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero_div  (zero_div)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something locks up
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Reference GF(16) multiply: full carry-less product, then reduce the
    // high bits with the full polynomial 1_0011
    function automatic logic [3:0] modelMul(input logic [3:0] x, input logic [3:0] z);
        logic [7:0] prod;
        logic [7:0] fullPoly;
        prod     = 8'h00;
        fullPoly = 8'h13;
        for (int i = 0; i < 4; i++) begin
            if (z[i]) prod = prod ^ ({4'b0, x} << i);
        end
        for (int i = 7; i >= 4; i--) begin
            if (prod[i]) prod = prod ^ (fullPoly << (i - 4));
        end
        return prod[3:0];
    endfunction

    // Reference power: repeated multiplication, x^0 = 1
    function automatic logic [3:0] modelPow(input logic [3:0] x, input int ex);
        logic [3:0] r;
        r = 4'h1;
        for (int i = 0; i < ex; i++) r = modelMul(r, x);
        return r;
    endfunction

    // Single comparison: counts it and reports on mismatch
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Consumer handshake: random stalls, always ready, or always stalled
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: checks the handshake exclusivity each cycle and scores every
    // result that the consumer takes
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ready_valid_exclusive", 8'(in_ready & out_valid), 8'h00);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got y=%0h, expected no result", y);
                end else begin
                    expItem = expQ.pop_front();
                    checkOutput("result_y", 8'(y), 8'(expItem[3:0]));
                    checkOutput("result_zero_div", 8'(zero_div), 8'(expItem[4]));
                    popCount++;
                end
            end
        end
    end

    // Wait at falling edges until the unit is idle, bounded
    task automatic waitIdle(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: got in_ready=0 after %0d cycles, expected 1", n);
        end
    endtask

    // Issue one request; returns just after the accept edge with the input
    // pins scrambled so that any late sampling shows up as a wrong result
    task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] te, input logic tinv,
                                 input logic [3:0] expY, input logic expZd, input bit expectResult);
        bit ok;
        waitIdle(ok);
        if (ok) begin
            a        = ta;
            e        = te;
            p        = POLY;
            inv      = tinv;
            in_valid = 1'b1;
            if (expectResult) expQ.push_back({expZd, expY});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 4'($urandom);
            e        = 4'($urandom);
            p        = 4'($urandom);
            inv      = 1'($urandom);
        end
    endtask

    // Wait for the scoreboard to empty, bounded
    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_queue_empty", 8'(expQ.size()), 8'h00);
    endtask

    initial begin
        int acceptCount;
        int popStart;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'h0;
        e        = 4'h0;
        p        = 4'h0;
        inv      = 1'b0;
        readyMode = 1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_in_ready", 8'(in_ready), 8'h01);
        checkOutput("reset_out_valid", 8'(out_valid), 8'h00);
        checkOutput("reset_y", 8'(y), 8'h00);
        checkOutput("reset_zero_div", 8'(zero_div), 8'h00);
        rst_n = 1'b1;

        // Inverse of 2 with latency and backpressure checks
        $display("[TB] inverse latency and backpressure");
        readyMode = 2;
        @(posedge clk);
        #2;
        applyStimulus(4'h2, 4'h0, 1'b1, 4'h9, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("latency_valid_T%0d", i), 8'(out_valid), (i == 4) ? 8'h01 : 8'h00);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_y", 8'(y), 8'h09);
            checkOutput("stall_zero_div", 8'(zero_div), 8'h00);
            checkOutput("stall_out_valid", 8'(out_valid), 8'h01);
            checkOutput("stall_in_ready", 8'(in_ready), 8'h00);
        end
        readyMode = 1;
        drain();

        // Directed power vectors
        $display("[TB] directed powers");
        applyStimulus(4'h2, 4'h5, 1'b0, 4'h6, 1'b0, 1'b1);
        applyStimulus(4'h3, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1);
        applyStimulus(4'h0, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1);

        // Zero inverse followed by inverse of one
        $display("[TB] zero inverse");
        applyStimulus(4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1);
        applyStimulus(4'h1, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1);
        drain();

        // Reset two cycles into RUN discards the operation
        $display("[TB] reset mid-operation");
        applyStimulus(4'h7, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 8'(out_valid), 8'h00);
        checkOutput("midreset_y", 8'(y), 8'h00);
        checkOutput("midreset_zero_div", 8'(zero_div), 8'h00);
        checkOutput("midreset_in_ready", 8'(in_ready), 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h2, 4'h0, 1'b1, 4'h9, 1'b0, 1'b1);
        drain();

        // in_valid held high: one accept per 6-cycle round trip
        $display("[TB] in_valid held high");
        begin
            bit ok;
            waitIdle(ok);
        end
        a           = 4'h2;
        e           = 4'h0;
        p           = POLY;
        inv         = 1'b1;
        in_valid    = 1'b1;
        acceptCount = 0;
        popStart    = popCount;
        for (int i = 0; i < 36; i++) begin
            if (in_ready) begin
                expQ.push_back({1'b0, 4'h9});
                acceptCount++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        checkOutput("hold_valid_accepts", 8'(acceptCount), 8'h06);
        checkOutput("hold_valid_results", 8'(popCount - popStart), 8'h06);

        // Exhaustive sweep with random consumer stalls
        $display("[TB] exhaustive sweep");
        readyMode = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ie = 0; ie < 16; ie++) begin
                applyStimulus(4'(ia), 4'(ie), 1'b0, modelPow(4'(ia), ie), 1'b0, 1'b1);
            end
        end
        for (int ia = 0; ia < 16; ia++) begin
            applyStimulus(4'(ia), 4'(ia * 5), 1'b1, modelPow(4'(ia), 14), (ia == 0), 1'b1);
        end
        drain();
        readyMode = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
